ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder: a 32-bit, word-organised on-chip SRAM slave.
- Sits behind the address decoder, which drives its HSEL. Its HRDATA/HREADYOUT/HRESP feed one slave input port of the slave-to-master response multiplexor.
- Supports byte, halfword and word transfers, programmable wait states, a write-protected low region, and the AHB-Lite two-cycle ERROR response.

Parameters:
- MEM_AW, 10: word-address width. Memory is 2^MEM_AW x 32 bits, indexed by HADDR[MEM_AW+1:2].
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase. Legal range 0..15.
- RO_WORDS, 0: word indices 0..RO_WORDS-1 are read-only. A write there returns ERROR.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word.
- HWDATA  in  32  data-phase write data.
- HREADY  in  1  global HREADY returned from the multiplexor.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Accept an address phase when HSEL & HTRANS[1] & HREADY.
  - On accept, register addr, write, size, lane mask and an error flag.
  - IDLE/BUSY transfers, or HSEL=0, start no data phase; the slave stays or returns to S_IDLE.
- Error flag is set by any of:
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0;
  - HWRITE=1 with word index < RO_WORDS.
- Lanes are little-endian:
  - byte: lane = HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- FSM states S_IDLE, S_ACC, S_ERR1, S_ERR2.
  - S_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
    - Accept with error → S_ERR1.
    - Accept without error → S_ACC with cnt=0.
    - Otherwise stay in S_IDLE.
  - S_ACC: HRESP=0; HREADYOUT = (cnt==WAIT_STATES).
    - While cnt < WAIT_STATES: cnt increments each cycle; HRDATA=0.
    - Completion cycle (cnt==WAIT_STATES):
      - read: HRDATA = mem[addr_r]; all 32 bits driven, and the master selects lanes;
      - write: HWDATA lanes in the mask are written at the clock edge ending the cycle.
    - Next state is decided by the new address phase sampled in the same cycle (pipelined): S_ERR1, S_ACC (cnt=0) or S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1. No memory write. → S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1. Accepts a new address phase like S_IDLE, which decides the next state.
- Latency for an OKAY transfer is WAIT_STATES+1 cycles from address phase to completion. Back-to-back transfers sustain one transfer per WAIT_STATES+1 cycles.
- Read-after-write to the same word in consecutive transfers returns the new data. The write commits before the read's data phase.
- While HREADYOUT=0, address-phase inputs are ignored because HREADY is low. The registered transfer is held unchanged.
- Reset, at any time including mid-wait or mid-error:
  - next cycle is S_IDLE, cnt=0, HREADYOUT=1, HRESP=0, HRDATA=0;
  - any pending write is discarded;
  - memory contents are not cleared.
- cnt is 4 bits. No wrap is possible within the legal WAIT_STATES range.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then word read of 0x10 back-to-back → read completes the cycle after its address phase with HRDATA=0xDEADBEEF; HREADYOUT stays 1 throughout.
- Byte write 0xAA to 0x11, then 0x55 to 0x13, over 0xDEADBEEF; word read of 0x10 → 0x55ADAABF… correction, the required value is 0x55ADAAEF. Halfword write 0x1234 to 0x12; read → 0x1234AAEF.
- WAIT_STATES=3: word read → HREADYOUT low for 3 cycles, high on the 4th with data; HADDR/HTRANS changes during the wait cycles have no effect.
- Halfword read at 0x01 → HREADYOUT 0 / HRESP 1, then HREADYOUT 1 / HRESP 1, then OKAY. With RO_WORDS=4, word write to 0x08 → same two-cycle ERROR, and a read-back of 0x08 is unchanged.
- HTRANS=BUSY, HTRANS=IDLE, and HSEL=0 with NONSEQ → HREADYOUT=1, HRESP=0, no memory change.
- Assert HRESET during the 2nd wait cycle of a write → next cycle HREADYOUT=1, HRESP=0, HRDATA=0; read-back after reset shows the old data.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: 2^MEM_AW x 32-bit word memory with byte lanes,
// programmable wait states, a write-protected low region and the two-cycle
// ERROR response. Outputs are decoded from registered state only.
module ahb_sram_slave #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ERR1, S_ERR2} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [3:0]          mask_q, mask_d;

    logic [31:0]         mem [2**MEM_AW];

    logic                accept;
    logic                err_a;
    logic [MEM_AW-1:0]   idx_a;
    logic                done;
    logic                mem_we;
    logic                unused_bits;

    // Little-endian lane enables for the transfer size and low address bits.
    function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
        logic [3:0] m;
        case (sz)
            3'd0:    m = 4'b0001 << a;
            3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign unused_bits = ^{HADDR[31:MEM_AW+2], HTRANS[0]};

    assign accept = HSEL & HTRANS[1] & HREADY;
    assign idx_a  = HADDR[MEM_AW+1:2];
    assign err_a  = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                  | (HWRITE & (int'(idx_a) < RO_WORDS));
    assign done   = (cnt_q == WS);

    // Next-state logic: a new address phase is only sampled when HREADY is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        mask_d  = mask_q;
        case (state_q)
            S_ACC: begin
                if (!done) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (accept) begin
                    state_d = err_a ? S_ERR1 : S_ACC;
                    cnt_d   = 4'd0;
                    addr_d  = idx_a;
                    write_d = HWRITE;
                    mask_d  = lane_mask(HSIZE, HADDR[1:0]);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                if (accept) begin
                    state_d = err_a ? S_ERR1 : S_ACC;
                    cnt_d   = 4'd0;
                    addr_d  = idx_a;
                    write_d = HWRITE;
                    mask_d  = lane_mask(HSIZE, HADDR[1:0]);
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control state: reset returns to S_IDLE; transfer attributes hold otherwise.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
        end
        addr_q <= addr_d;
        mask_q <= mask_d;
    end

    // Write commits at the edge ending the completion cycle; reset discards it.
    assign mem_we = (state_q == S_ACC) & done & write_q & ~HRESET;

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state_q == S_ERR1) ? 1'b0 :
                       (state_q == S_ACC)  ? done : 1'b1;
    assign HRESP     = (state_q == S_ERR1) | (state_q == S_ERR2);
    assign HRDATA    = ((state_q == S_ACC) & done & ~write_q) ? mem[addr_q] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Testbench for ahb_sram_slave: a zero-wait instance with a protected low
// region driven from a vector table, and a three-wait instance driven by
// hand-written wait-state and reset sequences.
module tb_ahb_sram_slave;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        er;
        logic        ep;
        logic [31:0] ed;
        logic        ne;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel3;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rd0, rd3;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl[27];

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(0), .RO_WORDS(4)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(3), .RO_WORDS(0)) u_dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy3),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3)
    );

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic w,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic er, input logic ep, input logic [31:0] ed,
                                input logic ne);
        vec_t v;
        v.sel = sel; v.tr = tr; v.w = w; v.sz = sz; v.a = a; v.wd = wd;
        v.er = er; v.ep = ep; v.ed = ed; v.ne = ne;
        return v;
    endfunction

    // One bus cycle: drive inputs just after the edge, then check outputs mid-cycle.
    // ne=1 means HRDATA must differ from ed instead of equal it.
    task automatic step(input string nm, input int which, input logic sel,
                        input logic [1:0] tr, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic rv,
                        input logic er, input logic ep, input logic [31:0] ed,
                        input logic ne);
        logic        ar, ap;
        logic [31:0] ad;
        logic        ok;
        @(posedge clk);
        #1;
        rst    = rv;
        hsel0  = (which == 0) ? sel : 1'b0;
        hsel3  = (which == 1) ? sel : 1'b0;
        htrans = tr;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        #1;
        ar = (which == 0) ? rdy0 : rdy3;
        ap = (which == 0) ? resp0 : resp3;
        ad = (which == 0) ? rd0 : rd3;
        ok = (ar === er) && (ap === ep) && (ne ? (ad !== ed) : (ad === ed));
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got ready=%0b resp=%0b rdata=%08h, required ready=%0b resp=%0b rdata%s%08h",
                     nm, ar, ap, ad, er, ep, ne ? "!=" : "=", ed);
        end
    endtask

    initial begin
        rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; htrans = IDL; hwrite = 1'b0;
        hsize = SW; haddr = '0; hwdata = '0;

        tbl[0]  = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 0, 32'h0, 0);
        tbl[1]  = mk(1, NSQ, 1, SW, 32'h10, 32'h0,        1, 0, 32'h0, 0);
        tbl[2]  = mk(1, NSQ, 0, SW, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0, 0);
        tbl[3]  = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF, 0);
        tbl[4]  = mk(1, NSQ, 1, SB, 32'h11, 32'h0,        1, 0, 32'h0, 0);
        tbl[5]  = mk(1, NSQ, 1, SB, 32'h13, 32'h0000AA00, 1, 0, 32'h0, 0);
        tbl[6]  = mk(1, NSQ, 0, SW, 32'h10, 32'h55000000, 1, 0, 32'h0, 0);
        tbl[7]  = mk(1, NSQ, 1, SH, 32'h12, 32'h0,        1, 0, 32'h55ADAAEF, 0);
        tbl[8]  = mk(1, NSQ, 0, SW, 32'h10, 32'h12340000, 1, 0, 32'h0, 0);
        tbl[9]  = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 0, 32'h1234AAEF, 0);
        tbl[10] = mk(1, NSQ, 0, SH, 32'h01, 32'h0,        1, 0, 32'h0, 0);
        tbl[11] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        0, 1, 32'h0, 0);
        tbl[12] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 1, 32'h0, 0);
        tbl[13] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 0, 32'h0, 0);
        tbl[14] = mk(1, NSQ, 1, SW, 32'h08, 32'h0,        1, 0, 32'h0, 0);
        tbl[15] = mk(0, IDL, 0, SW, 32'h00, 32'hCAFEF00D, 0, 1, 32'h0, 0);
        tbl[16] = mk(1, NSQ, 0, SW, 32'h08, 32'h0,        1, 1, 32'h0, 0);
        tbl[17] = mk(1, NSQ, 0, 3'd3, 32'h20, 32'h0,      1, 0, 32'hCAFEF00D, 1);
        tbl[18] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        0, 1, 32'h0, 0);
        tbl[19] = mk(1, NSQ, 0, SW, 32'h22, 32'h0,        1, 1, 32'h0, 0);
        tbl[20] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        0, 1, 32'h0, 0);
        tbl[21] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 1, 32'h0, 0);
        tbl[22] = mk(1, BSY, 1, SW, 32'h10, 32'h0,        1, 0, 32'h0, 0);
        tbl[23] = mk(1, IDL, 1, SW, 32'h10, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
        tbl[24] = mk(0, NSQ, 1, SW, 32'h10, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
        tbl[25] = mk(1, NSQ, 0, SW, 32'h10, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
        tbl[26] = mk(0, IDL, 0, SW, 32'h00, 32'h0,        1, 0, 32'h1234AAEF, 0);

        repeat (3) @(posedge clk);

        // Reset state of the wait-state instance, then the zero-wait vector table.
        step("rst_dut3", 1, 0, IDL, 0, SW, 32'h0, 32'h0, 0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 27; i++) begin
            step($sformatf("vec%0d", i), 0, tbl[i].sel, tbl[i].tr, tbl[i].w, tbl[i].sz,
                 tbl[i].a, tbl[i].wd, 0, tbl[i].er, tbl[i].ep, tbl[i].ed, tbl[i].ne);
        end

        // Reset in the first error cycle.
        step("rerr_acc",  0, 1, NSQ, 0, SH, 32'h03, 32'h0, 0, 1, 0, 32'h0, 0);
        step("rerr_err1", 0, 0, IDL, 0, SW, 32'h00, 32'h0, 1, 0, 1, 32'h0, 0);
        step("rerr_idle", 0, 0, IDL, 0, SW, 32'h00, 32'h0, 0, 1, 0, 32'h0, 0);

        // Three wait states: write then read, address-phase noise during waits.
        step("ws_w_addr", 1, 1, NSQ, 1, SW, 32'h40, 32'h0,      0, 1, 0, 32'h0, 0);
        step("ws_w_wt0",  1, 1, NSQ, 0, SW, 32'h40, 32'h11223344, 0, 0, 0, 32'h0, 0);
        step("ws_w_wt1",  1, 1, NSQ, 1, SB, 32'h44, 32'h11223344, 0, 0, 0, 32'h0, 0);
        step("ws_w_wt2",  1, 1, NSQ, 0, 3'd3, 32'h45, 32'h11223344, 0, 0, 0, 32'h0, 0);
        step("ws_w_done", 1, 1, NSQ, 0, SW, 32'h40, 32'h11223344, 0, 1, 0, 32'h0, 0);
        step("ws_r_wt0",  1, 1, NSQ, 1, SW, 32'h48, 32'h0,      0, 0, 0, 32'h0, 0);
        step("ws_r_wt1",  1, 1, NSQ, 0, 3'd5, 32'h41, 32'h0,    0, 0, 0, 32'h0, 0);
        step("ws_r_wt2",  1, 1, BSY, 1, SW, 32'h4C, 32'h0,      0, 0, 0, 32'h0, 0);
        step("ws_r_done", 1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 1, 0, 32'h11223344, 0);
        step("ws_idle",   1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 1, 0, 32'h0, 0);

        // Reset during the second wait cycle of a write discards the write.
        step("rw_addr",   1, 1, NSQ, 1, SW, 32'h40, 32'h0,      0, 1, 0, 32'h0, 0);
        step("rw_wt0",    1, 0, IDL, 0, SW, 32'h00, 32'h99999999, 0, 0, 0, 32'h0, 0);
        step("rw_wt1",    1, 0, IDL, 0, SW, 32'h00, 32'h99999999, 1, 0, 0, 32'h0, 0);
        step("rw_after",  1, 1, NSQ, 0, SW, 32'h40, 32'h0,      0, 1, 0, 32'h0, 0);
        step("rw_r_wt0",  1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 0, 0, 32'h0, 0);
        step("rw_r_wt1",  1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 0, 0, 32'h0, 0);
        step("rw_r_wt2",  1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 0, 0, 32'h0, 0);
        step("rw_r_done", 1, 0, IDL, 0, SW, 32'h00, 32'h0,      0, 1, 0, 32'h11223344, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
